// File: rtl/positadd_arbiter_if.sv
// positadd_arbiter_if
//   Requester-side bus of the shared posit adder arbiter.
//   master : requester side (drives requests, receives grants and responses)
//   slave  : arbiter side (receives requests, drives grants and responses)
// Signals
//   req_valid   [NREQ]     per-requester request valid
//   req_ready   [NREQ]     per-requester grant (one-hot or zero)
//   req_in1     [32*NREQ]  operand A, requester i at [32*i+:32]
//   req_in2     [32*NREQ]  operand B, requester i at [32*i+:32]
//   resp_valid  [NREQ]     one-hot result pulse
//   resp_result [32]       shared result bus
//   resp_inf    [1]        shared inf flag
//   resp_zero   [1]        shared zero flag
interface positadd_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_in1;
    logic [32*NREQ-1:0]   req_in2;
    logic [NREQ-1:0]      resp_valid;
    logic [31:0]          resp_result;
    logic                 resp_inf;
    logic                 resp_zero;

    modport master (
        output req_valid, req_in1, req_in2,
        input  req_ready, resp_valid, resp_result, resp_inf, resp_zero
    );

    modport slave (
        input  req_valid, req_in1, req_in2,
        output req_ready, resp_valid, resp_result, resp_inf, resp_zero
    );
endinterface

// File: rtl/positadd_arbiter.sv
// positadd_arbiter
//   Shares one pipelined posit adder (fixed LATENCY, no stall) among NREQ
//   requesters. Round-robin arbitration issues at most one add per cycle; a
//   tag pipeline follows each op so its result is returned to its requester.
// Ports
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   enable           1 = grants allowed; 0 = no new grants, in-flight drain
//   bus              requester interface (slave modport)
//   busy             an op is in flight or a response is being presented
//   add_start/in1/in2                  issue side toward the adder
//   add_result/inf/zero/done           result side from the adder
//   err_done         sticky add_done/tag-valid mismatch flag
//                    (present only with POSITADD_ARB_DONE_CHECK_EN defined)
// Configuration macro: POSITADD_ARB_DONE_CHECK_EN
module positadd_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned LATENCY = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    positadd_arbiter_if.slave    bus,
    output logic                 busy,
    output logic                 add_start,
    output logic [31:0]          add_in1,
    output logic [31:0]          add_in2,
    input  logic [31:0]          add_result,
    input  logic                 add_inf,
    input  logic                 add_zero,
    input  logic                 add_done
`ifdef POSITADD_ARB_DONE_CHECK_EN
    ,
    output logic                 err_done
`endif
);
    localparam int unsigned TAGW = $clog2(NREQ);
    localparam logic [TAGW:0] NREQ_W = (TAGW+1)'(NREQ);
    localparam logic [TAGW-1:0] LAST = TAGW'(NREQ - 1);

    logic [TAGW-1:0] ptr;
    logic [TAGW-1:0] gnt_idx;
    logic            gnt_any;
    logic            xfer;
    logic [TAGW:0]   scan;
    logic [31:0]     sel_in1;
    logic [31:0]     sel_in2;
    logic [TAGW-1:0] issue_tag;

    logic [LATENCY:1] pipe_v;
    logic [TAGW-1:0]  pipe_tag [1:LATENCY];

    // Round-robin search starting at ptr; the sum is one bit wider than the
    // pointer so the wrap works for any NREQ, not only powers of two.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr} + (TAGW+1)'(k);
            if (scan >= NREQ_W) begin
                scan = scan - NREQ_W;
            end
            if (!gnt_any && bus.req_valid[scan[TAGW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = scan[TAGW-1:0];
            end
        end
    end

    assign xfer = gnt_any & enable & ~reset;

    always_comb begin
        bus.req_ready = '0;
        if (xfer) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_in1 = '0;
        sel_in2 = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (gnt_idx == TAGW'(k)) begin
                sel_in1 = bus.req_in1[32*k +: 32];
                sel_in2 = bus.req_in2[32*k +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            add_start <= 1'b0;
            add_in1   <= '0;
            add_in2   <= '0;
            issue_tag <= '0;
        end else begin
            add_start <= xfer;
            if (xfer) begin
                ptr       <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
                issue_tag <= gnt_idx;
                add_in1   <= sel_in1;
                add_in2   <= sel_in2;
            end
        end
    end

    // Stage LATENCY lines up with add_done of the op issued LATENCY cycles ago.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_v <= '0;
            for (int unsigned i = 1; i <= LATENCY; i++) begin
                pipe_tag[i] <= '0;
            end
        end else begin
            pipe_v[1]   <= add_start;
            pipe_tag[1] <= issue_tag;
            for (int unsigned i = 2; i <= LATENCY; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    // Routing uses only the tag valid, so done pulses from ops cut off by a
    // reset fall on an empty pipeline and are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.resp_valid  <= '0;
            bus.resp_result <= '0;
            bus.resp_inf    <= 1'b0;
            bus.resp_zero   <= 1'b0;
        end else begin
            bus.resp_valid <= '0;
            if (pipe_v[LATENCY]) begin
                bus.resp_valid[pipe_tag[LATENCY]] <= 1'b1;
                bus.resp_result <= add_result;
                bus.resp_inf    <= add_inf;
                bus.resp_zero   <= add_zero;
            end
        end
    end

    assign busy = add_start | (|pipe_v) | (|bus.resp_valid);

`ifdef POSITADD_ARB_DONE_CHECK_EN
    localparam int unsigned CNTW = $clog2(LATENCY + 1);
    localparam logic [CNTW-1:0] SETTLE = CNTW'(LATENCY);

    logic [CNTW-1:0] settle_cnt;

    // The adder is not reset, so its done stream is untrusted until every
    // op issued before the reset has had time to flush out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt <= '0;
            err_done   <= 1'b0;
        end else if (settle_cnt != SETTLE) begin
            settle_cnt <= settle_cnt + 1'b1;
        end else if (add_done != pipe_v[LATENCY]) begin
            err_done <= 1'b1;
        end
    end
`else
    logic unused_add_done;
    assign unused_add_done = add_done;
`endif

endmodule

// File: tb/tb_positadd_arbiter.sv
// tb_positadd_arbiter
//   Directed bench for positadd_arbiter with a behavioural stand-in for the
//   fixed-latency posit adder and a queue scoreboard of expected responses.
module tb_positadd_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned LAT  = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    always #5 clk = ~clk;

    positadd_arbiter_if #(.NREQ(NREQ)) bus ();

    logic        busy;
    logic        add_start;
    logic [31:0] add_in1;
    logic [31:0] add_in2;
    logic [31:0] add_result;
    logic        add_inf;
    logic        add_zero;
    logic        add_done;
    logic        force_done = 1'b0;
`ifdef POSITADD_ARB_DONE_CHECK_EN
    logic        err_done;
`endif

    positadd_arbiter #(.NREQ(NREQ), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bus        (bus),
        .busy       (busy),
        .add_start  (add_start),
        .add_in1    (add_in1),
        .add_in2    (add_in2),
        .add_result (add_result),
        .add_inf    (add_inf),
        .add_zero   (add_zero),
        .add_done   (add_done)
`ifdef POSITADD_ARB_DONE_CHECK_EN
        ,
        .err_done   (err_done)
`endif
    );

    // Adder stand-in: 1.0+1.0 gives the posit 2.0; otherwise an
    // order-sensitive mix so swapped or misrouted operands show up.
    function automatic logic [33:0] add_model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (a == 32'h4000_0000 && b == 32'h4000_0000) r = 32'h4800_0000;
        else r = a + {b[15:0], b[31:16]};
        return {^a[7:0], ^b[7:0], r};
    endfunction

    logic [LAT:1] st_v = '0;
    logic [33:0]  st_d [1:LAT];
    always @(posedge clk) begin
        st_v[1] <= add_start;
        st_d[1] <= add_model(add_in1, add_in2);
        for (int i = 2; i <= LAT; i++) begin
            st_v[i] <= st_v[i-1];
            st_d[i] <= st_d[i-1];
        end
    end
    assign add_done   = st_v[LAT] | force_done;
    assign add_inf    = st_d[LAT][33];
    assign add_zero   = st_d[LAT][32];
    assign add_result = st_d[LAT][31:0];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int unsigned req;
        logic [33:0] data;
        int unsigned due;
    } exp_t;
    exp_t sbq [$];

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sbq.delete();
        end else begin
            for (int r = 0; r < NREQ; r++) begin
                if (bus.req_valid[r] && bus.req_ready[r]) begin
                    e.req  = r;
                    e.data = add_model(bus.req_in1[32*r +: 32], bus.req_in2[32*r +: 32]);
                    e.due  = cyc + LAT + 2;
                    sbq.push_back(e);
                end
            end
            if (|bus.resp_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_resp", 32'(bus.resp_valid), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("resp_valid", 32'(bus.resp_valid), 32'd1 << e.req);
                    check("resp_result", bus.resp_result, e.data[31:0]);
                    check("resp_inf", 32'(bus.resp_inf), 32'(e.data[33]));
                    check("resp_zero", 32'(bus.resp_zero), 32'(e.data[32]));
                    check("resp_cycle", cyc, e.due);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        repeat (16) tick();
        smp();
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_sb_empty"}, 32'(sbq.size()), 32'd0);
    endtask

    task automatic set_ops(input int r, input int k);
        bus.req_in1[32*r +: 32] = {4'hA, 4'(r), 8'(k), 16'h5A5A};
        bus.req_in2[32*r +: 32] = {8'(k * 3 + r), 8'h3C, 8'(r), 8'(k)};
    endtask

    initial begin
        int seen;
        bus.req_valid = '1;
        bus.req_in1   = '0;
        bus.req_in2   = '0;
        for (int r = 0; r < NREQ; r++) set_ops(r, 0);

        // Reset state with every requester asking.
        tick();
        smp();
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_add_start", 32'(add_start), 32'd0);
        check("rst_add_in1", add_in1, 32'd0);
        check("rst_resp_result", bus.resp_result, 32'd0);
`ifdef POSITADD_ARB_DONE_CHECK_EN
        check("rst_err_done", 32'(err_done), 32'd0);
`endif
        tick();
        bus.req_valid = '0;
        reset = 1'b0;
        enable = 1'b1;
        repeat (2) tick();

        // Single op 1.0 + 1.0 from requester 2.
        bus.req_valid = 4'b0100;
        bus.req_in1[64 +: 32] = 32'h4000_0000;
        bus.req_in2[64 +: 32] = 32'h4000_0000;
        smp();
        check("t1_ready", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = '0;
        smp();
        check("t1_add_start", 32'(add_start), 32'd1);
        check("t1_add_in1", add_in1, 32'h4000_0000);
        drain("t1");

        // Full-rate round robin from a fresh pointer.
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int r = 0; r < NREQ; r++) set_ops(r, 1);
        bus.req_valid = '1;
        for (int k = 0; k < 12; k++) begin
            smp();
            check("t2_grant", 32'(bus.req_ready), 32'd1 << (k % 4));
            if (k > 0) check("t2_add_start", 32'(add_start), 32'd1);
            tick();
            set_ops(k % 4, k + 2);
        end
        bus.req_valid = '0;
        smp();
        check("t2_add_start_last", 32'(add_start), 32'd1);
        tick();
        smp();
        check("t2_add_start_off", 32'(add_start), 32'd0);
        drain("t2");

        // Requesters 1 and 3 only, pointer moved to 2 first.
        tick();
        bus.req_valid = 4'b0010;
        smp();
        check("t3_setup_grant", 32'(bus.req_ready), 32'h2);
        tick();
        set_ops(1, 20);
        bus.req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            smp();
            check("t3_grant", 32'(bus.req_ready), (k % 2 == 0) ? 32'h8 : 32'h2);
            tick();
            set_ops((k % 2 == 0) ? 3 : 1, 21 + k);
        end
        bus.req_valid = '0;
        drain("t3");

        // Reset with five ops in flight.
        tick();
        bus.req_valid = '1;
        repeat (5) tick();
        bus.req_valid = '0;
        repeat (2) tick();
        reset = 1'b1;
        bus.req_valid = '1;
        smp();
        check("t4_rst_ready", 32'(bus.req_ready), 32'd0);
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_add_start", 32'(add_start), 32'd0);
        tick();
        smp();
        check("t4_rst_hold_ready", 32'(bus.req_ready), 32'd0);
        tick();
        reset = 1'b0;
        smp();
        check("t4_ptr_zero", 32'(bus.req_ready), 32'h1);
        check("t4_busy", 32'(busy), 32'd0);
`ifdef POSITADD_ARB_DONE_CHECK_EN
        check("t4_err_done", 32'(err_done), 32'd0);
`endif
        tick();
        bus.req_valid = '0;
        drain("t4");
`ifdef POSITADD_ARB_DONE_CHECK_EN
        check("t4_err_done_after", 32'(err_done), 32'd0);
`endif

        // enable drop with requests still pending.
        tick();
        bus.req_valid = '1;
        repeat (3) tick();
        enable = 1'b0;
        smp();
        check("t5_ready_cut", 32'(bus.req_ready), 32'd0);
        check("t5_add_start_last", 32'(add_start), 32'd1);
        tick();
        smp();
        check("t5_ready_off", 32'(bus.req_ready), 32'd0);
        check("t5_add_start_off", 32'(add_start), 32'd0);
        seen = 0;
        if (|bus.resp_valid) seen++;
        for (int i = 0; i < 30 && seen < 3; i++) begin
            tick();
            smp();
            if (|bus.resp_valid) seen++;
        end
        check("t5_resp_count", 32'(seen), 32'd3);
        check("t5_busy_at_last", 32'(busy), 32'd1);
        check("t5_ready_still_off", 32'(bus.req_ready), 32'd0);
        tick();
        smp();
        check("t5_busy_fall", 32'(busy), 32'd0);
        tick();
        bus.req_valid = '0;
        enable = 1'b1;

`ifdef POSITADD_ARB_DONE_CHECK_EN
        // Spurious done with an empty pipeline.
        tick();
        force_done = 1'b1;
        smp();
        check("t6_err_before", 32'(err_done), 32'd0);
        tick();
        force_done = 1'b0;
        smp();
        check("t6_err_set", 32'(err_done), 32'd1);
        repeat (5) tick();
        smp();
        check("t6_err_sticky", 32'(err_done), 32'd1);
        tick();
        reset = 1'b1;
        smp();
        check("t6_err_cleared", 32'(err_done), 32'd0);
        tick();
        reset = 1'b0;
`endif

        drain("final");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
